// File: rtl/uart_ascii_rx.sv
// UART 8N1 receiver with a decimal command decoder: digits accumulate into a
// value that is published on carriage return; bad frames or characters flag err_o.
module uart_ascii_rx #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned MAX_DIGITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic        rx_i,
  output logic [13:0] value_o,
  output logic        value_vld_o,
  output logic        err_o
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned DIG_W        = $clog2(MAX_DIGITS + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic             rx_s1_q, rx_s2_q, rx_prev_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_rdy_q, byte_rdy_d;
  logic             frm_err_q, frm_err_d;
  logic [13:0]      acc_q, acc_d;
  logic [DIG_W-1:0] count_q, count_d;
  logic             discard_q, discard_d;
  logic [13:0]      value_q, value_d;
  logic             vld_q, vld_d;
  logic             err_q, err_d;

  logic is_digit;
  assign is_digit = (shift_q >= 8'h30) && (shift_q <= 8'h39);

  // Synchronizer and previous-sample register for start-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx_i;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      byte_rdy_q <= 1'b0;
      frm_err_q  <= 1'b0;
      acc_q      <= '0;
      count_q    <= '0;
      discard_q  <= 1'b0;
      value_q    <= '0;
      vld_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      byte_rdy_q <= byte_rdy_d;
      frm_err_q  <= frm_err_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      discard_q  <= discard_d;
      value_q    <= value_d;
      vld_q      <= vld_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    byte_rdy_d = 1'b0;
    frm_err_d  = 1'b0;
    acc_d      = acc_q;
    count_d    = count_q;
    discard_d  = discard_q;
    value_d    = value_q;
    vld_d      = 1'b0;
    err_d      = 1'b0;

    // Receiver: every sample is taken when the baud counter wraps
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (rx_prev_q && !rx_s2_q) state_d = S_START;
      end
      S_START: begin
        if (baud_q == CNT_W'(HALF_BIT - 1)) begin
          baud_d  = '0;
          state_d = rx_s2_q ? S_IDLE : S_DATA;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (baud_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          baud_d  = '0;
          shift_d = {rx_s2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (baud_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          baud_d     = '0;
          state_d    = S_IDLE;
          byte_rdy_d = rx_s2_q;
          frm_err_d  = !rx_s2_q;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Decoder runs one clk after the stop sample
    if (frm_err_q) begin
      err_d     = 1'b1;
      acc_d     = '0;
      count_d   = '0;
      discard_d = 1'b0;
    end else if (byte_rdy_q) begin
      if (is_digit) begin
        if (discard_q) begin
          discard_d = 1'b1;
        end else if (count_q == DIG_W'(MAX_DIGITS)) begin
          err_d     = 1'b1;
          discard_d = 1'b1;
        end else begin
          acc_d   = acc_q * 14'd10 + 14'(shift_q[3:0]);
          count_d = count_q + DIG_W'(1);
        end
      end else if (shift_q == 8'h0D) begin
        if (count_q != '0 && !discard_q) begin
          value_d = acc_q;
          vld_d   = 1'b1;
        end
        acc_d     = '0;
        count_d   = '0;
        discard_d = 1'b0;
      end else begin
        err_d     = 1'b1;
        discard_d = 1'b1;
      end
    end

    // Disable aborts reception and clears the command, keeping the last value
    if (!en_i) begin
      state_d    = S_IDLE;
      baud_d     = '0;
      bit_d      = '0;
      byte_rdy_d = 1'b0;
      frm_err_d  = 1'b0;
      acc_d      = '0;
      count_d    = '0;
      discard_d  = 1'b0;
      value_d    = value_q;
      vld_d      = 1'b0;
      err_d      = 1'b0;
    end
  end

  assign value_o     = value_q;
  assign value_vld_o = vld_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_uart_ascii_rx.sv
// Directed bench for uart_ascii_rx at 16 clk per bit: ASCII command scenarios,
// framing errors, glitches and mid-frame reset/disable.
module tb_uart_ascii_rx;

  localparam int unsigned CPB = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_i;
  logic        rx_i;
  logic [13:0] value_o;
  logic        value_vld_o;
  logic        err_o;

  int vectors = 0;
  int miscompares = 0;
  int vld_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  uart_ascii_rx #(.CLK_FREQ(16), .BAUD(1), .MAX_DIGITS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .en_i        (en_i),
    .rx_i        (rx_i),
    .value_o     (value_o),
    .value_vld_o (value_vld_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled away from the active edge
  always @(negedge clk) begin
    if (value_vld_o === 1'b1) vld_cnt++;
    if (err_o === 1'b1) err_cnt++;
    if (value_vld_o === 1'b1 && err_o === 1'b1) both_cnt++;
  end

  task automatic clear_counts();
    vld_cnt  = 0;
    err_cnt  = 0;
    both_cnt = 0;
  endtask

  task automatic bit_time(input logic v, input int n);
    rx_i = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    bit_time(1'b0, CPB);
    for (int i = 0; i < 8; i++) bit_time(b[i], CPB);
    bit_time(stop_bit, CPB);
    if (!stop_bit) bit_time(1'b1, CPB);
  endtask

  task automatic check_counts(input string name, input int exp_vld, input int exp_err,
                              input logic [13:0] exp_val);
    repeat (4) @(negedge clk);
    vectors++;
    if (vld_cnt !== exp_vld) begin
      miscompares++;
      $display("FAIL %s vld pulses: got %0d expected %0d", name, vld_cnt, exp_vld);
    end
    vectors++;
    if (err_cnt !== exp_err) begin
      miscompares++;
      $display("FAIL %s err pulses: got %0d expected %0d", name, err_cnt, exp_err);
    end
    vectors++;
    if (value_o !== exp_val) begin
      miscompares++;
      $display("FAIL %s value_o: got %0d expected %0d", name, value_o, exp_val);
    end
    vectors++;
    if (both_cnt !== 0) begin
      miscompares++;
      $display("FAIL %s vld/err overlap: got %0d expected 0", name, both_cnt);
    end
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    en_i = 1'b1;
    rx_i = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({value_o, value_vld_o, err_o} !== 16'h0) begin
      miscompares++;
      $display("FAIL reset outputs: got %h expected 0000", {value_o, value_vld_o, err_o});
    end
    clear_counts();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_counts("after_reset", 0, 0, 14'd0);
  endtask

  task automatic test_basic_123();
    clear_counts();
    send_byte(8'h31, 1'b1);
    send_byte(8'h32, 1'b1);
    send_byte(8'h33, 1'b1);
    check_counts("digits_123_pre_cr", 0, 0, 14'd0);
    clear_counts();
    send_byte(8'h0D, 1'b1);
    check_counts("cmd_123", 1, 0, 14'd123);
  endtask

  task automatic test_lone_cr();
    clear_counts();
    send_byte(8'h0D, 1'b1);
    check_counts("lone_cr", 0, 0, 14'd123);
  endtask

  task automatic test_bad_char();
    clear_counts();
    send_byte(8'h31, 1'b1);
    send_byte(8'h41, 1'b1);
    check_counts("bad_char_A", 0, 1, 14'd123);
    send_byte(8'h35, 1'b1);
    send_byte(8'h0D, 1'b1);
    check_counts("bad_char_cr", 0, 1, 14'd123);
    send_byte(8'h37, 1'b1);
    send_byte(8'h0D, 1'b1);
    check_counts("bad_char_then_7", 1, 1, 14'd7);
    clear_counts();
    send_byte(8'h3F, 1'b1);
    send_byte(8'h3F, 1'b1);
    send_byte(8'h0D, 1'b1);
    check_counts("question_marks", 0, 2, 14'd7);
  endtask

  task automatic test_overflow();
    clear_counts();
    for (int i = 0; i < 5; i++) send_byte(8'h39, 1'b1);
    check_counts("overflow_5th", 0, 1, 14'd7);
    send_byte(8'h0D, 1'b1);
    check_counts("overflow_cr", 0, 1, 14'd7);
    clear_counts();
    for (int i = 0; i < 4; i++) send_byte(8'h39, 1'b1);
    send_byte(8'h0D, 1'b1);
    check_counts("max_9999", 1, 0, 14'd9999);
  endtask

  task automatic test_framing();
    clear_counts();
    send_byte(8'h35, 1'b0);
    check_counts("framing_err", 0, 1, 14'd9999);
    clear_counts();
    send_byte(8'h34, 1'b1);
    send_byte(8'h0D, 1'b1);
    check_counts("after_framing_4", 1, 0, 14'd4);
  endtask

  task automatic test_glitch();
    clear_counts();
    bit_time(1'b0, CPB / 4);
    bit_time(1'b1, 12 * CPB);
    check_counts("glitch", 0, 0, 14'd4);
  endtask

  task automatic test_abort();
    // Reset in the middle of "8"
    clear_counts();
    send_byte(8'h31, 1'b1);
    bit_time(1'b0, CPB);
    bit_time(1'b0, 3 * CPB);
    rst = 1'b1;
    bit_time(1'b0, 2);
    rst = 1'b0;
    bit_time(1'b1, 12 * CPB);
    check_counts("rst_midframe", 0, 0, 14'd0);
    send_byte(8'h36, 1'b1);
    send_byte(8'h0D, 1'b1);
    check_counts("after_rst_6", 1, 0, 14'd6);
    // Disable in the middle of "8" after a pending digit
    clear_counts();
    send_byte(8'h32, 1'b1);
    bit_time(1'b0, CPB);
    bit_time(1'b0, 3 * CPB);
    en_i = 1'b0;
    bit_time(1'b0, 4);
    bit_time(1'b1, 4);
    en_i = 1'b1;
    bit_time(1'b1, 12 * CPB);
    check_counts("en_midframe", 0, 0, 14'd6);
    send_byte(8'h36, 1'b1);
    send_byte(8'h0D, 1'b1);
    check_counts("after_en_6", 1, 0, 14'd6);
  endtask

  task automatic test_back_to_back();
    clear_counts();
    send_byte(8'h38, 1'b1);
    send_byte(8'h30, 1'b1);
    send_byte(8'h35, 1'b1);
    send_byte(8'h0D, 1'b1);
    send_byte(8'h32, 1'b1);
    send_byte(8'h0D, 1'b1);
    check_counts("back_to_back", 2, 0, 14'd2);
  endtask

  initial begin
    test_reset();
    test_basic_123();
    test_lone_cr();
    test_bad_char();
    test_overflow();
    test_framing();
    test_glitch();
    test_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_ascii_rx.md
UART_ASCII_RX -- requirements
Module: uart_ascii_rx

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, SHALL give the system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, SHALL give the line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, 868 at defaults).
REQ-003 Parameter MAX_DIGITS, default 4, SHALL give the maximum number of decimal digits per command.
REQ-004 Port clk  input  1  SHALL be the single system clock; all logic is on its rising edge.
REQ-005 Port rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-006 Port en_i  input  1  SHALL be the receive enable, driven from the debounced UART enable switch.
REQ-007 Port rx_i  input  1  SHALL be the asynchronous serial line: 8N1 format, LSB first, idle high.
REQ-008 Port value_o  output  14  SHALL hold the last accepted decimal value (0..9999).
REQ-009 Port value_vld_o  output  1  SHALL pulse for one clk when value_o is updated.
REQ-010 Port err_o  output  1  SHALL pulse for one clk on any framing, character or overflow error.

Function
REQ-011 rx_i SHALL pass through a 2-flop synchronizer, reset value 1; all decisions use the synchronized bit.
REQ-012 The receiver FSM SHALL have the states IDLE, START, DATA and STOP.
REQ-013 IDLE -> START SHALL occur on a synchronized 1->0 transition while en_i=1.
REQ-014 START SHALL sample the line at CLKS_PER_BIT/2; if the line is 0, go to DATA; if 1, treat it as a glitch: return to IDLE with no output.
REQ-015 DATA SHALL sample 8 bits, each CLKS_PER_BIT after the previous sample, LSB first, with a 3-bit bit counter.
REQ-016 STOP SHALL sample the line once CLKS_PER_BIT after the last data bit.
  - Line 1: the byte SHALL be valid.
  - Line 0: framing error; err_o pulses, the byte is dropped and the decoder is cleared (REQ-021).
  - The FSM then returns to IDLE in either case.
REQ-017 The decoder SHALL process each valid byte in the clk after the stop sample.
REQ-018 Byte 0x30..0x39 with discard=0 and count<MAX_DIGITS SHALL set acc = acc*10 + (byte-0x30) and count = count+1.
  - acc is 14 bits wide; count is wide enough to hold MAX_DIGITS.
REQ-019 Byte 0x30..0x39 with count=MAX_DIGITS SHALL be an overflow: err_o pulses, discard is set, acc is unchanged.
REQ-020 Byte 0x0D with count>0 and discard=0 SHALL load value_o<=acc and pulse value_vld_o in the same clk.
  - Byte 0x0D with count=0 SHALL be ignored: no pulse.
REQ-021 Byte 0x0D SHALL always clear acc, count and discard.
REQ-022 Any other byte, including 0x3F, SHALL pulse err_o and set discard.
  - While discard=1, digits SHALL be ignored without further err_o pulses.
  - While discard=1, non-digit non-CR bytes SHALL pulse err_o again.
REQ-023 Latency SHALL be exactly 1 clk from the stop-bit sample of a byte to its value_vld_o or err_o pulse.
REQ-024 value_vld_o and err_o SHALL never be asserted in the same clk.
REQ-025 value_o SHALL hold its value until the next accepted command or rst.
REQ-026 en_i=0 SHALL force the FSM to IDLE and clear acc, count and discard within 1 clk, aborting any frame in progress silently.
  - en_i=0 SHALL leave value_o unchanged.
REQ-027 A start edge arriving in the clk after STOP completes SHALL be accepted (back-to-back frames).

Reset
REQ-028 rst=1 SHALL force: FSM=IDLE, synchronizer=1, bit and baud counters=0, acc=0, count=0, discard=0, value_o=0, value_vld_o=0, err_o=0.
REQ-029 rst asserted mid-frame SHALL abort the frame; after release, the receiver SHALL wait for a new falling edge.
REQ-030 No output pulse SHALL be generated during rst or in the first clk after release.

Verification
REQ-031 Benches SHALL override CLKS_PER_BIT via CLK_FREQ/BAUD, e.g. CLK_FREQ=16, BAUD=1 gives 16 clk per bit.
REQ-032 Scenario: send "1","2","3",0x0D -> value_o=123, exactly one value_vld_o pulse, no err_o.
REQ-033 Scenario: send 0x0D alone -> no value_vld_o, no err_o, value_o unchanged.
REQ-034 Scenario: send "1","A","5",0x0D,"7",0x0D -> one err_o on "A", no pulse on the first 0x0D, then value_o=7 with one pulse.
REQ-035 Scenario: send "9","9","9","9","9",0x0D -> err_o on the 5th digit, no value_vld_o; then "9","9","9","9",0x0D -> value_o=9999.
REQ-036 Scenario: frame 0x35 with stop bit 0 -> one err_o pulse, acc cleared; then "4",0x0D -> value_o=4.
REQ-037 Scenario: rx_i low pulse of CLKS_PER_BIT/4 clk -> no output; rst or en_i=0 mid-frame of "8" -> no output, and the next "6",0x0D gives value_o=6.
